// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM states, algorithm selects
// and a constant-friendly clog2 used for sizing the shift-exponent register.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration, purely combinational: subtractive Euclid or binary (Stein)
// depending on mode. Subtraction is always larger minus smaller.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  input  logic             mode,
  output logic [WIDTH-1:0] next_x,
  output logic [WIDTH-1:0] next_y,
  output logic [KW-1:0]    next_k
);

  logic binary;
  assign binary = (mode == MODE_BIN);

  always_comb begin
    next_x = x;
    next_y = y;
    next_k = k;
    if (binary && !x[0] && !y[0]) begin
      // common factor of two is stripped and remembered in k
      next_x = x >> 1;
      next_y = y >> 1;
      next_k = k + KW'(1);
    end else if (binary && !x[0]) begin
      next_x = x >> 1;
    end else if (binary && !y[0]) begin
      next_y = y >> 1;
    end else if (x < y) begin
      next_y = y - x;
    end else begin
      next_x = x - y;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Multi-cycle GCD engine: go/ready start, CHECK/STEP iteration loop, registered
// result with a one-cycle done pulse and step count; supports sync abort.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = WIDTH + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              go,
  input  logic              abort,
  input  logic              mode,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  gcd_out,
  output logic [STEP_W-1:0] steps
);

  localparam int KW = clog2(WIDTH);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  x, y, next_x, next_y;
  logic [KW-1:0]     k, next_k;
  logic              m;
  logic [STEP_W-1:0] cnt;
  logic [WIDTH-1:0]  res;
  logic              finished;

  // With x==y, x|y equals x, so one expression covers both terminal cases.
  assign res      = (x | y) << k;
  assign finished = (x == '0) || (y == '0) || (x == y);

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .x      (x),
    .y      (y),
    .k      (k),
    .mode   (m),
    .next_x (next_x),
    .next_y (next_y),
    .next_k (next_k)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (go && !abort) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (abort)         state_nxt = IDLE;
        else if (finished) state_nxt = DONE;
        else               state_nxt = STEP;
      end
      STEP: begin
        busy      = 1'b1;
        state_nxt = abort ? IDLE : CHECK;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x       <= '0;
      y       <= '0;
      k       <= '0;
      m       <= MODE_SUB;
      cnt     <= '0;
      gcd_out <= '0;
      steps   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go && !abort) begin
            x   <= a_in;
            y   <= b_in;
            m   <= mode;
            k   <= '0;
            cnt <= '0;
          end
        end
        CHECK: begin
          if (abort) begin
            cnt <= '0;
          end else if (finished) begin
            gcd_out <= res;
            steps   <= cnt;
          end
        end
        STEP: begin
          if (abort) begin
            cnt <= '0;
          end else begin
            x   <= next_x;
            y   <= next_y;
            k   <= next_k;
            cnt <= cnt + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: directed vectors push expected result, step
// count and done cycle; a negedge monitor pops and checks on every done pulse.
module tb_gcd_engine;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       ready, busy, done;
  logic [7:0] gcd_out;
  logic [8:0] steps;

  typedef struct {
    logic [7:0] g;
    logic [8:0] s;
    int         c;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_g = '0;
  logic [8:0] last_s = '0;

  gcd_engine #(.WIDTH(8), .STEP_W(9)) dut (
    .clk     (clk),
    .clr     (clr),
    .go      (go),
    .abort   (abort),
    .mode    (mode),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out),
    .steps   (steps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // done seen after edge cyc belongs to cycle cyc+1
  always @(negedge clk) begin
    if (!clr && done) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done gcd_out=%0d steps=%0d cycle=%0d", gcd_out, steps, cyc + 1);
      end else begin
        mon_e = q.pop_front();
        if (gcd_out !== mon_e.g || steps !== mon_e.s || (cyc + 1) != mon_e.c) begin
          bad++;
          $display("FAIL result got gcd=%0d steps=%0d cycle=%0d, need gcd=%0d steps=%0d cycle=%0d",
                   gcd_out, steps, cyc + 1, mon_e.g, mon_e.s, mon_e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, want);
    end
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic md,
                       input logic [7:0] eg, input logic [8:0] es, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(ready === 1'b1 && done === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_wait_timeout", 32'(ready), 32'd1);
    go   = 1'b1;
    a_in = a;
    b_in = b;
    mode = md;
    @(posedge clk);
    #1;
    go = 1'b0;
    check("accept_ready", 32'(ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    if (push) begin
      e.g = eg;
      e.s = es;
      e.c = cyc + 2 + 2 * int'(es);
      q.push_back(e);
      last_g = eg;
      last_s = es;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_gcd"}, 32'(gcd_out), 32'd0);
    check({tag, "_steps"}, 32'(steps), 32'd0);
  endtask

  initial begin
    int n;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    clr = 1'b0;

    start(8'd12, 8'd18, 1'b0, 8'd6, 9'd2, 1'b1);
    start(8'd12, 8'd18, 1'b1, 8'd6, 9'd4, 1'b1);
    for (int md = 0; md < 2; md++) begin
      start(8'd0, 8'd5, md[0], 8'd5, 9'd0, 1'b1);
      start(8'd7, 8'd0, md[0], 8'd7, 9'd0, 1'b1);
      start(8'd0, 8'd0, md[0], 8'd0, 9'd0, 1'b1);
    end
    start(8'd255, 8'd255, 1'b0, 8'd255, 9'd0, 1'b1);
    start(8'd8, 8'd4, 1'b1, 8'd4, 9'd3, 1'b1);

    // worst case, with go pulses and different operands while busy
    start(8'd255, 8'd1, 1'b0, 8'd1, 9'd254, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    go = 1'b1; a_in = 8'd6; b_in = 8'd4; mode = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_during_go", 32'(busy), 32'd1);
    go = 1'b0;

    // abort in cycle E+4 of (12,18)
    start(8'd12, 8'd18, 1'b0, 8'd0, 9'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_gcd_hold", 32'(gcd_out), 32'(last_g));
    check("abort_steps_hold", 32'(steps), 32'(last_s));
    repeat (8) @(posedge clk);

    // abort together with go in IDLE: nothing starts
    @(negedge clk);
    go = 1'b1; abort = 1'b1; a_in = 8'd9; b_in = 8'd6; mode = 1'b0;
    @(posedge clk);
    #1;
    go = 1'b0; abort = 1'b0;
    check("abort_go_ready", 32'(ready), 32'd1);
    check("abort_go_busy", 32'(busy), 32'd0);

    start(8'd9, 8'd6, 1'b0, 8'd3, 9'd2, 1'b1);

    // clr mid-computation
    start(8'd255, 8'd1, 1'b0, 8'd0, 9'd0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_reset_outputs("clr");
    @(negedge clk);
    clr = 1'b0;
    start(8'd100, 8'd75, 1'b1, 8'd25, 9'd4, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("pending_results", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised multi-cycle GCD engine with integrated datapath and controller, the successor of the fixed-width GCD control/datapath pair. Computes gcd(a, b) of two WIDTH-bit unsigned operands using a runtime-selected algorithm: subtractive Euclid or binary (Stein). The block sits behind a go/ready start handshake and returns a registered result, a one-cycle done pulse and an iteration count. It also supports abort and defines results for zero operands.

## Interface
- WIDTH, 8: operand and result width; legal range is 2 and up.
- STEP_W, WIDTH+1: width of the step counter. This is sufficient for the subtractive worst case of 2^WIDTH−2 steps.
- clk  in  1  sole clock; all logic is on its rising edge.
- clr  in  1  reset, asynchronous and active-high. Forces the IDLE state and the reset values listed below.
- go  in  1  start request; accepted only when ready=1.
- abort  in  1  synchronous abort. Returns the engine to IDLE from any busy state.
- mode  in  1  algorithm select, sampled with go: 0 = subtractive, 1 = binary.
- a_in, b_in  in  WIDTH  operands, sampled with go.
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in CHECK and STEP.
- done  out  1  one-cycle pulse when the result is valid.
- gcd_out  out  WIDTH  last result; held until the next done.
- steps  out  STEP_W  number of STEP cycles taken by the last computation; updated together with gcd_out.

## Operation
- States: IDLE, CHECK, STEP, DONE. The state encoding is defined in the package.
- Reset values: state=IDLE, ready=1, busy=0, done=0, gcd_out=0, steps=0. Internal x, y, k and the step count are all 0.
- IDLE, go=1: load x←a_in, y←b_in, m←mode, k←0, cnt←0; go to CHECK.
- CHECK:
  - If x==0 or y==0: res←(x|y)<<k, go to DONE.
  - Else if x==y: res←x<<k, go to DONE.
  - Else go to STEP.
- STEP, subtractive (m=0): if x<y then y←y−x, else x←x−y. k stays 0.
- STEP, binary (m=1), the first matching rule applies:
  - x and y both even: x←x>>1, y←y>>1, k←k+1.
  - x even: x←x>>1.
  - y even: y←y>>1.
  - Otherwise subtract the smaller from the larger.
- STEP always does cnt←cnt+1 and then returns to CHECK.
- DONE:
  - Entry registers gcd_out←res and steps←cnt; done=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
  - go during DONE is ignored. A new start needs go in IDLE.
- Arithmetic:
  - Subtraction is always larger minus smaller, so it never underflows.
  - k ≤ WIDTH−1; k width is clog2(WIDTH).
  - res fits in WIDTH bits because gcd ≤ max(a, b).
- Zero operands: gcd(0, b)=b, gcd(a, 0)=a, gcd(0, 0)=0, each with steps=0.
- go while busy is ignored; operands in flight are not disturbed.
- abort in CHECK or STEP returns to IDLE next edge. done stays 0, gcd_out and steps are unchanged, and cnt is cleared.
- abort in IDLE or DONE has no effect. If abort and go are both high in IDLE, abort wins and nothing starts.
- clr mid-operation: immediate return to IDLE with the reset values; no done.

## Timing
- go sampled at edge E; CHECK occupies cycle E+1.
- A computation with N steps asserts done in cycle E+2+2N. Each iteration costs 2 cycles (CHECK + STEP).
- ready falls the cycle after go is accepted and rises again in the DONE cycle. Back-to-back minimum is one IDLE cycle between done and the next accepted go.
- gcd_out and steps change only on the edge entering DONE.

## Structure
- gcd_pkg holds:
  - the state enum (IDLE, CHECK, STEP, DONE);
  - the mode constants MODE_SUB=0 and MODE_BIN=1;
  - a clog2 helper function.
- Sub-module gcd_step: purely combinational, one iteration. Inputs x, y, k and mode; outputs next x, y, k.
  - Instanced once in gcd_engine.
  - The FSM, registers, counter and handshake live in gcd_engine.

## Test plan
- Subtractive, WIDTH=8: a=12, b=18, mode=0 → done in cycle E+6, gcd_out=6, steps=2.
- Binary, WIDTH=8: a=12, b=18, mode=1 → done in cycle E+10, gcd_out=6, steps=4 (k=1 path).
- Zeros: (0, 5) gives 5; (7, 0) gives 7; (0, 0) gives 0. Each has steps=0 and done in cycle E+2, in both modes.
- Worst case subtractive: a=255, b=1 → steps=254, done in cycle E+510, gcd_out=1. Verify that go pulses during busy are ignored.
- abort asserted in cycle E+4 of (12, 18): back in IDLE next cycle, no done, gcd_out and steps hold their previous values. A following go with (9, 6) in mode 0 gives 3.
- clr pulse mid-computation: all outputs return to their reset values asynchronously. A subsequent go with (100, 75) in mode 1 gives 25.
